// File: rtl/vga_sync_gen.sv
// VGA 640x480 timing generator: column/row counters, sync pulses, active flag,
// line/frame strobes, pipeline-delayed sync/active and RGB blanking.
module vga_sync_gen #(
    parameter int unsigned TOTAL_COLS    = 800,
    parameter int unsigned TOTAL_ROWS    = 525,
    parameter int unsigned ACTIVE_COLS   = 640,
    parameter int unsigned ACTIVE_ROWS   = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_WIDTH  = 96,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_WIDTH  = 2,
    parameter bit          SYNC_ACTIVE   = 1'b0,
    parameter int unsigned PIPE_DELAY    = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Active,
    output logic       o_Line_Start,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count,
    output logic       o_HSync_D,
    output logic       o_VSync_D,
    output logic       o_Active_D,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video
);

    localparam logic [9:0]  COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0]  ROW_LAST = 10'(TOTAL_ROWS - 1);
    // 11-bit bounds so a sync window ending at 1024 does not wrap
    localparam logic [10:0] ACT_COLS = 11'(ACTIVE_COLS);
    localparam logic [10:0] ACT_ROWS = 11'(ACTIVE_ROWS);
    localparam logic [10:0] HS_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [10:0] HS_STOP  = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] VS_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [10:0] VS_STOP  = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t     state_q;
    logic [9:0] col_nxt;
    logic [9:0] row_nxt;
    logic [7:0] frame_nxt;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       active_nxt;
    logic [2:0] dly_q [PIPE_DELAY];

    always_comb begin
        col_nxt   = o_Col_Count;
        row_nxt   = o_Row_Count;
        frame_nxt = o_Frame_Count;
        if (state_q == IDLE) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (o_Col_Count == COL_LAST) begin
            col_nxt = '0;
            if (o_Row_Count == ROW_LAST) begin
                row_nxt   = '0;
                frame_nxt = o_Frame_Count + 8'd1;
            end else begin
                row_nxt = o_Row_Count + 10'd1;
            end
        end else begin
            col_nxt = o_Col_Count + 10'd1;
        end

        hsync_nxt  = ({1'b0, col_nxt} >= HS_START && {1'b0, col_nxt} < HS_STOP)
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_nxt  = ({1'b0, row_nxt} >= VS_START && {1'b0, row_nxt} < VS_STOP)
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        active_nxt = ({1'b0, col_nxt} < ACT_COLS) && ({1'b0, row_nxt} < ACT_ROWS);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= IDLE;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_HSync       <= ~SYNC_ACTIVE;
            o_VSync       <= ~SYNC_ACTIVE;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Frame_Count <= '0;
            for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else if (i_Enable) begin
            state_q       <= RUN;
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_HSync       <= hsync_nxt;
            o_VSync       <= vsync_nxt;
            o_Active      <= active_nxt;
            o_Line_Start  <= (col_nxt == '0);
            o_Frame_Start <= (col_nxt == '0) && (row_nxt == '0);
            o_Frame_Count <= frame_nxt;
            // Stage 0 captures the pre-edge flags, so the tap is PIPE_DELAY edges old
            dly_q[0] <= {o_HSync, o_VSync, o_Active};
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end else begin
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end
    end

    assign o_HSync_D  = dly_q[PIPE_DELAY-1][2];
    assign o_VSync_D  = dly_q[PIPE_DELAY-1][1];
    assign o_Active_D = dly_q[PIPE_DELAY-1][0];

    assign o_Red_Video = o_Active_D ? i_Red_Video : '0;
    assign o_Grn_Video = o_Active_D ? i_Grn_Video : '0;
    assign o_Blu_Video = o_Active_D ? i_Blu_Video : '0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a shrunken, inverted-polarity
// instance, both checked every cycle against a linear pixel-position model.
module tb_vga_sync_gen;

    localparam int TC  [2] = '{800, 12};
    localparam int TR  [2] = '{525, 6};
    localparam int AC  [2] = '{640, 8};
    localparam int AR  [2] = '{480, 4};
    localparam int HFP [2] = '{16, 1};
    localparam int HSW [2] = '{96, 2};
    localparam int VFP [2] = '{10, 1};
    localparam int VSW [2] = '{2, 1};
    localparam bit SA  [2] = '{1'b0, 1'b1};
    localparam int PD  [2] = '{2, 3};

    logic       i_Clk;
    logic       i_Rst_L;
    logic       i_Enable;
    logic [3:0] i_Red_Video, i_Grn_Video, i_Blu_Video;

    logic [1:0][9:0] col_o, row_o;
    logic [1:0]      hs_o, vs_o, act_o, ls_o, fs_o, hsd_o, vsd_o, actd_o;
    logic [1:0][7:0] fc_o;
    logic [1:0][3:0] r_o, g_o, b_o;

    int checks = 0;
    int errors = 0;

    vga_sync_gen u_dut0 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Enable(i_Enable),
        .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
        .o_Col_Count(col_o[0]), .o_Row_Count(row_o[0]),
        .o_HSync(hs_o[0]), .o_VSync(vs_o[0]), .o_Active(act_o[0]),
        .o_Line_Start(ls_o[0]), .o_Frame_Start(fs_o[0]), .o_Frame_Count(fc_o[0]),
        .o_HSync_D(hsd_o[0]), .o_VSync_D(vsd_o[0]), .o_Active_D(actd_o[0]),
        .o_Red_Video(r_o[0]), .o_Grn_Video(g_o[0]), .o_Blu_Video(b_o[0])
    );

    vga_sync_gen #(
        .TOTAL_COLS(12), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
        .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1),
        .SYNC_ACTIVE(1'b1), .PIPE_DELAY(3)
    ) u_dut1 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Enable(i_Enable),
        .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
        .o_Col_Count(col_o[1]), .o_Row_Count(row_o[1]),
        .o_HSync(hs_o[1]), .o_VSync(vs_o[1]), .o_Active(act_o[1]),
        .o_Line_Start(ls_o[1]), .o_Frame_Start(fs_o[1]), .o_Frame_Count(fc_o[1]),
        .o_HSync_D(hsd_o[1]), .o_VSync_D(vsd_o[1]), .o_Active_D(actd_o[1]),
        .o_Red_Video(r_o[1]), .o_Grn_Video(g_o[1]), .o_Blu_Video(b_o[1])
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Model: position is a single pixel index within the frame
    bit          m_run [2] = '{1'b0, 1'b0};
    int          m_pos [2] = '{0, 0};
    int          m_frm [2] = '{0, 0};
    bit          m_stb [2] = '{1'b0, 1'b0};
    int unsigned m_n   [2] = '{0, 0};
    logic [2:0]  m_hist [2][8];

    function automatic int exp_col(int k);
        return m_run[k] ? (m_pos[k] % TC[k]) : 0;
    endfunction

    function automatic int exp_row(int k);
        return m_run[k] ? (m_pos[k] / TC[k]) : 0;
    endfunction

    function automatic logic [2:0] exp_trip(int k);
        int c, r;
        logic hs, vs, act;
        if (!m_run[k]) return {~SA[k], ~SA[k], 1'b0};
        c   = exp_col(k);
        r   = exp_row(k);
        hs  = (c >= AC[k] + HFP[k] && c < AC[k] + HFP[k] + HSW[k]) ? SA[k] : ~SA[k];
        vs  = (r >= AR[k] + VFP[k] && r < AR[k] + VFP[k] + VSW[k]) ? SA[k] : ~SA[k];
        act = (c < AC[k]) && (r < AR[k]);
        return {hs, vs, act};
    endfunction

    function automatic logic [2:0] exp_dly(int k);
        if (m_n[k] >= PD[k]) return m_hist[k][(m_n[k] - PD[k]) % 8];
        return 3'b000;
    endfunction

    always @(posedge i_Clk or negedge i_Rst_L) begin
        for (int k = 0; k < 2; k++) begin
            if (!i_Rst_L) begin
                m_run[k] = 1'b0;
                m_pos[k] = 0;
                m_frm[k] = 0;
                m_stb[k] = 1'b0;
                m_n[k]   = 0;
            end else if (i_Enable) begin
                m_hist[k][m_n[k] % 8] = exp_trip(k);
                m_n[k] = m_n[k] + 1;
                if (m_run[k]) begin
                    m_pos[k] = (m_pos[k] + 1) % (TC[k] * TR[k]);
                    if (m_pos[k] == 0) m_frm[k] = (m_frm[k] + 1) % 256;
                end else begin
                    m_run[k] = 1'b1;
                end
                m_stb[k] = 1'b1;
            end else begin
                m_stb[k] = 1'b0;
            end
        end
    end

    task automatic chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] actual %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge i_Clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [2:0] t, d;
            bit ls;
            t  = exp_trip(k);
            d  = exp_dly(k);
            ls = m_run[k] && m_stb[k] && (exp_col(k) == 0);
            chk("col",    k, int'(col_o[k]),  exp_col(k));
            chk("row",    k, int'(row_o[k]),  exp_row(k));
            chk("hsync",  k, int'(hs_o[k]),   int'(t[2]));
            chk("vsync",  k, int'(vs_o[k]),   int'(t[1]));
            chk("active", k, int'(act_o[k]),  int'(t[0]));
            chk("line_start",  k, int'(ls_o[k]), int'(ls));
            chk("frame_start", k, int'(fs_o[k]), int'(ls && exp_row(k) == 0));
            chk("frame_count", k, int'(fc_o[k]), m_frm[k]);
            chk("hsync_d",  k, int'(hsd_o[k]),  int'(d[2]));
            chk("vsync_d",  k, int'(vsd_o[k]),  int'(d[1]));
            chk("active_d", k, int'(actd_o[k]), int'(d[0]));
            chk("red", k, int'(r_o[k]), d[0] ? int'(i_Red_Video) : 0);
            chk("grn", k, int'(g_o[k]), d[0] ? int'(i_Grn_Video) : 0);
            chk("blu", k, int'(b_o[k]), d[0] ? int'(i_Blu_Video) : 0);
        end
    end

    task automatic adv(int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic rand_inputs(int en_odds);
        i_Enable    = ($urandom_range(0, en_odds - 1) != 0);
        i_Red_Video = 4'($urandom);
        i_Grn_Video = 4'($urandom);
        i_Blu_Video = 4'($urandom);
    endtask

    initial begin
        i_Rst_L = 1'b0;
        i_Enable = 1'b0;
        i_Red_Video = '0;
        i_Grn_Video = '0;
        i_Blu_Video = '0;
        adv(3);
        chk("lit_rst_col",   0, int'(col_o[0]), 0);
        chk("lit_rst_hs",    0, int'(hs_o[0]),  1);
        chk("lit_rst_hs",    1, int'(hs_o[1]),  0);
        chk("lit_rst_act",   0, int'(act_o[0]), 0);
        i_Rst_L = 1'b1;
        adv(3);
        chk("lit_idle_fs",   0, int'(fs_o[0]),  0);

        i_Enable = 1'b1;
        i_Red_Video = 4'hF;
        adv(1);
        chk("lit_first_col", 0, int'(col_o[0]), 0);
        chk("lit_first_row", 0, int'(row_o[0]), 0);
        chk("lit_first_fs",  0, int'(fs_o[0]),  1);
        chk("lit_first_ls",  0, int'(ls_o[0]),  1);
        chk("lit_first_act", 0, int'(act_o[0]), 1);
        chk("lit_first_fc",  0, int'(fc_o[0]),  0);
        adv(1);
        chk("lit_second_col", 0, int'(col_o[0]), 1);
        chk("lit_second_fs",  0, int'(fs_o[0]),  0);
        adv(639);
        chk("lit_c640_col",  0, int'(col_o[0]),  640);
        chk("lit_c640_act",  0, int'(act_o[0]),  0);
        chk("lit_c640_actd", 0, int'(actd_o[0]), 1);
        chk("lit_c640_red",  0, int'(r_o[0]),    15);
        chk("lit_e641_fc",   1, int'(fc_o[1]),   8);
        chk("lit_e641_col",  1, int'(col_o[1]),  4);
        chk("lit_e641_row",  1, int'(row_o[1]),  5);
        chk("lit_e641_vs",   1, int'(vs_o[1]),   1);
        adv(1);
        chk("lit_c641_actd", 0, int'(actd_o[0]), 1);
        adv(1);
        chk("lit_c642_actd", 0, int'(actd_o[0]), 0);
        chk("lit_c642_red",  0, int'(r_o[0]),    0);
        adv(13);
        chk("lit_c655_hs",   0, int'(hs_o[0]),   1);
        adv(1);
        chk("lit_c656_hs",   0, int'(hs_o[0]),   0);
        adv(95);
        chk("lit_c751_hs",   0, int'(hs_o[0]),   0);
        adv(1);
        chk("lit_c752_hs",   0, int'(hs_o[0]),   1);
        adv(47);
        chk("lit_c799_col",  0, int'(col_o[0]),  799);
        adv(1);
        chk("lit_r1_col",    0, int'(col_o[0]),  0);
        chk("lit_r1_row",    0, int'(row_o[0]),  1);
        chk("lit_r1_ls",     0, int'(ls_o[0]),   1);
        chk("lit_r1_fs",     0, int'(fs_o[0]),   0);
        adv(900);

        repeat (200) begin
            i_Enable = ~i_Enable;
            adv(1);
        end
        repeat (3000) begin
            rand_inputs(4);
            adv(1);
        end

        i_Rst_L = 1'b0;
        #1;
        chk("lit_mid_rst_col", 0, int'(col_o[0]), 0);
        chk("lit_mid_rst_row", 0, int'(row_o[0]), 0);
        chk("lit_mid_rst_hs",  0, int'(hs_o[0]),  1);
        chk("lit_mid_rst_fc",  1, int'(fc_o[1]),  0);
        chk("lit_mid_rst_red", 1, int'(r_o[1]),   0);
        adv(2);
        i_Rst_L = 1'b1;
        i_Enable = 1'b0;
        adv(2);
        i_Enable = 1'b1;
        adv(1);
        chk("lit_restart_col", 0, int'(col_o[0]), 0);
        chk("lit_restart_fs",  0, int'(fs_o[0]),  1);
        chk("lit_restart_fc",  1, int'(fc_o[1]),  0);

        repeat (30000) begin
            rand_inputs(16);
            adv(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
